// File: rtl/execute_unit_mc.sv
// execute_unit_mc
//   Registered execute stage. Evaluates R/I/U/B instructions in a single cycle
//   and MUL/DIVU/REMU with an iterative path that does one step per cycle.
//   Valid/ready handshakes are used on both the input and the output side.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (operands + opcode/func)
//   rs1_data, rs2_data    source operands
//   imm                   sign-extended immediate
//   opcode, func          instruction class and operation select
//   out_valid / out_ready output handshake
//   sonuc                 result
//   pc_update             branch taken
//   we                    register-file write enable
//   hata                  illegal opcode/func flag
module execute_unit_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      opcode,
    input  logic [3:0]      func,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] sonuc,
    output logic            pc_update,
    output logic            we,
    output logic            hata
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;
    localparam logic [6:0] OP_M = 7'b0011111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [1:0] {M_MUL, M_DIVU, M_REMU} mop_t;

    state_t          state_reg;
    mop_t            mop_reg;
    logic [SHW-1:0]  cnt_reg;
    logic [XLEN-1:0] opa_reg;   // MUL: shifted multiplicand, DIV: dividend -> quotient
    logic [XLEN-1:0] opb_reg;   // MUL: shifted multiplier,   DIV: divisor
    logic [XLEN-1:0] acc_reg;   // MUL: partial product,      DIV: partial remainder
    logic            out_valid_reg;
    logic [XLEN-1:0] sonuc_reg;
    logic            pc_update_reg;
    logic            we_reg;
    logic            hata_reg;

    logic out_free;
    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = (state_reg == S_IDLE) && out_free;

    assign out_valid = out_valid_reg;
    assign sonuc     = sonuc_reg;
    assign pc_update = pc_update_reg;
    assign we        = we_reg;
    assign hata      = hata_reg;

    // ---------------- single-cycle decode / evaluate ----------------
    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] alu_res;
    logic            alu_br, alu_we, alu_err, is_m;
    mop_t            m_kind;

    always_comb begin
        op2     = (opcode == OP_I) ? imm : rs2_data;
        sh      = op2[SHW-1:0];
        alu_res = '0;
        alu_br  = 1'b0;
        alu_we  = 1'b0;
        alu_err = 1'b0;
        is_m    = 1'b0;
        m_kind  = M_MUL;
        case (opcode)
            OP_R, OP_I: begin
                alu_we = 1'b1;
                case (func)
                    4'b0000: alu_res = rs1_data + op2;
                    4'b0111: alu_res = rs1_data & op2;
                    4'b0110: alu_res = rs1_data | op2;
                    4'b0100: alu_res = rs1_data ^ op2;
                    4'b0001: alu_res = rs1_data << sh;
                    4'b0101: alu_res = rs1_data >> sh;
                    // SUB and ASR exist only in the register form
                    4'b1000: if (opcode == OP_R) alu_res = rs1_data - op2;
                             else alu_err = 1'b1;
                    4'b1101: if (opcode == OP_R) alu_res = $unsigned($signed(rs1_data) >>> sh);
                             else alu_err = 1'b1;
                    default: alu_err = 1'b1;
                endcase
            end
            OP_U: begin
                alu_we  = 1'b1;
                alu_res = {{(XLEN-20){1'b0}}, imm[19:0]};
            end
            OP_B: begin
                case (func)
                    4'b0011: alu_br = 1'b1;
                    4'b0000: alu_br = (rs1_data == rs2_data);
                    4'b0001: alu_br = (rs1_data != rs2_data);
                    4'b0100: alu_br = ($signed(rs1_data) <  $signed(rs2_data));
                    4'b0101: alu_br = ($signed(rs1_data) >= $signed(rs2_data));
                    4'b0110: alu_br = (rs1_data <  rs2_data);
                    4'b0111: alu_br = (rs1_data >= rs2_data);
                    default: alu_err = 1'b1;
                endcase
            end
            OP_M: begin
                case (func)
                    4'b0000: begin is_m = 1'b1; m_kind = M_MUL;  end
                    4'b0100: begin is_m = 1'b1; m_kind = M_DIVU; end
                    4'b0110: begin is_m = 1'b1; m_kind = M_REMU; end
                    default: alu_err = 1'b1;
                endcase
            end
            default: alu_err = 1'b1;
        endcase
        if (alu_err) begin
            alu_res = '0;
            alu_we  = 1'b0;
            alu_br  = 1'b0;
        end
    end

    // ---------------- iterative step datapath ----------------
    logic [XLEN-1:0] mul_acc_next;
    logic [XLEN:0]   rem_shift;
    logic            can_sub;
    logic [XLEN-1:0] rem_diff;

    assign mul_acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
    assign rem_shift    = {acc_reg, opa_reg[XLEN-1]};
    assign can_sub      = (rem_shift >= {1'b0, opb_reg});
    // Only used when can_sub holds, so the difference always fits in XLEN bits.
    assign rem_diff     = rem_shift[XLEN-1:0] - opb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            mop_reg       <= M_MUL;
            cnt_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            sonuc_reg     <= '0;
            pc_update_reg <= 1'b0;
            we_reg        <= 1'b0;
            hata_reg      <= 1'b0;
        end else begin
            // Consumer took the result; a load below overrides this.
            if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (is_m) begin
                            mop_reg   <= m_kind;
                            cnt_reg   <= '0;
                            opa_reg   <= rs1_data;
                            opb_reg   <= rs2_data;
                            acc_reg   <= '0;
                            state_reg <= (m_kind == M_MUL) ? S_MUL : S_DIV;
                        end else begin
                            sonuc_reg     <= alu_res;
                            pc_update_reg <= alu_br;
                            we_reg        <= alu_we;
                            hata_reg      <= alu_err;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    // The last step waits until the output slot is free so
                    // DONE can always load the result.
                    if (cnt_reg != LAST_STEP || out_free) begin
                        if (state_reg == S_MUL) begin
                            acc_reg <= mul_acc_next;
                            opa_reg <= opa_reg << 1;
                            opb_reg <= opb_reg >> 1;
                        end else if (can_sub) begin
                            acc_reg <= rem_diff;
                            opa_reg <= {opa_reg[XLEN-2:0], 1'b1};
                        end else begin
                            acc_reg <= rem_shift[XLEN-1:0];
                            opa_reg <= {opa_reg[XLEN-2:0], 1'b0};
                        end
                        cnt_reg <= cnt_reg + SHW'(1);
                        if (cnt_reg == LAST_STEP) state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    sonuc_reg     <= (mop_reg == M_DIVU) ? opa_reg : acc_reg;
                    pc_update_reg <= 1'b0;
                    we_reg        <= 1'b1;
                    hata_reg      <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_unit_mc.sv
// Directed testbench for execute_unit_mc (XLEN=32).
module tb_execute_unit_mc;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [3:0]  func;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sonuc;
    logic        pc_update;
    logic        we;
    logic        hata;

    int checks = 0;
    int errors = 0;

    execute_unit_mc #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .opcode(opcode), .func(func),
        .out_valid(out_valid), .out_ready(out_ready),
        .sonuc(sonuc), .pc_update(pc_update), .we(we), .hata(hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction on the input side.
    task automatic drive(input logic [6:0] op, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        opcode   = op;
        func     = fn;
        rs1_data = a;
        rs2_data = b;
        imm      = i;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (sonuc !== 32'h0) begin errors++; $display("FAIL reset_sonuc got %h want 0", sonuc); end
        checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL reset_pc_update got %b want 0", pc_update); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (hata !== 1'b0) begin errors++; $display("FAIL reset_hata got %b want 0", hata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset done");
    endtask

    task automatic test_alu_stream;
        logic [3:0]  fn [3]  = '{4'b0000, 4'b1000, 4'b1101};
        logic [31:0] a  [3]  = '{32'd5, 32'd3, 32'h8000_0000};
        logic [31:0] b  [3]  = '{32'hFFFF_FFF9, 32'd5, 32'd4};
        logic [31:0] ex [3]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hF800_0000};
        drive(7'b0000001, fn[0], a[0], b[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready[%0d] got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            $display("alu[%0d] sonuc=%h we=%b hata=%b", i, sonuc, we, hata);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_out_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (sonuc !== ex[i]) begin errors++; $display("FAIL alu_sonuc[%0d] got %h want %h", i, sonuc, ex[i]); end
            checks++; if (we !== 1'b1 || hata !== 1'b0) begin errors++; $display("FAIL alu_flags[%0d] got we=%b hata=%b want we=1 hata=0", i, we, hata); end
            if (i < 2) drive(7'b0000001, fn[i+1], a[i+1], b[i+1], 32'h0);
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", out_valid); end
    endtask

    task automatic test_branch;
        logic [3:0]  fn [3] = '{4'b0110, 4'b0100, 4'b0111};
        logic [31:0] a  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] b  [3] = '{32'd1, 32'd1, 32'd1};
        logic        ex [3] = '{1'b0, 1'b1, 1'b1};
        drive(7'b0001111, fn[0], a[0], b[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("branch[%0d] pc_update=%b we=%b sonuc=%h", i, pc_update, we, sonuc);
            checks++; if (pc_update !== ex[i]) begin errors++; $display("FAIL br_pc_update[%0d] got %b want %b", i, pc_update, ex[i]); end
            checks++; if (we !== 1'b0 || sonuc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL br_out[%0d] got we=%b sonuc=%h ov=%b want 0/0/1", i, we, sonuc, out_valid); end
            if (i < 2) drive(7'b0001111, fn[i+1], a[i+1], b[i+1], 32'h0);
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv;
        logic [3:0]  fn [3] = '{4'b0000, 4'b0100, 4'b0110};
        logic [31:0] a  [3] = '{32'h0001_0003, 32'd100, 32'd100};
        logic [31:0] b  [3] = '{32'h0002_0005, 32'd7, 32'd7};
        logic [31:0] ex [3] = '{32'h000B_000F, 32'd14, 32'd2};
        int n;
        int rdy_seen;
        for (int i = 0; i < 3; i++) begin
            drive(7'b0011111, fn[i], a[i], b[i], 32'h0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0; rdy_seen = 0;
            while (n < 60) begin
                @(posedge clk); #1;
                n++;
                if (out_valid === 1'b1) break;
                if (in_ready !== 1'b0) rdy_seen++;
            end
            $display("muldiv[%0d] sonuc=%h latency=%0d", i, sonuc, n);
            checks++; if (n !== 33) begin errors++; $display("FAIL md_latency[%0d] got %0d want 33", i, n); end
            checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL md_in_ready[%0d] got %0d busy cycles with in_ready want 0", i, rdy_seen); end
            checks++; if (sonuc !== ex[i]) begin errors++; $display("FAIL md_sonuc[%0d] got %h want %h", i, sonuc, ex[i]); end
            checks++; if (we !== 1'b1 || hata !== 1'b0) begin errors++; $display("FAIL md_flags[%0d] got we=%b hata=%b want 1/0", i, we, hata); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        logic [3:0]  fn [2] = '{4'b0100, 4'b0110};
        logic [31:0] ex [2] = '{32'hFFFF_FFFF, 32'd42};
        int n;
        for (int i = 0; i < 2; i++) begin
            drive(7'b0011111, fn[i], 32'd42, 32'd0, 32'h0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (n < 60) begin
                @(posedge clk); #1;
                n++;
                if (out_valid === 1'b1) break;
            end
            $display("divzero[%0d] sonuc=%h latency=%0d hata=%b", i, sonuc, n, hata);
            checks++; if (n !== 33) begin errors++; $display("FAIL dz_latency[%0d] got %0d want 33", i, n); end
            checks++; if (sonuc !== ex[i]) begin errors++; $display("FAIL dz_sonuc[%0d] got %h want %h", i, sonuc, ex[i]); end
            checks++; if (hata !== 1'b0) begin errors++; $display("FAIL dz_hata[%0d] got %b want 0", i, hata); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int bad;
        out_ready = 1'b0;
        drive(7'b0000011, 4'b0000, 32'd10, 32'd999, 32'd20);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || sonuc !== 32'd30) begin errors++; $display("FAIL bp_first got ov=%b sonuc=%h want 1/0000001e", out_valid, sonuc); end
        drive(7'b0000011, 4'b0000, 32'd1, 32'd999, 32'd2);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (sonuc !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        $display("backpressure hold sonuc=%h in_ready=%b", sonuc, in_ready);
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("backpressure next sonuc=%h", sonuc);
        checks++; if (out_valid !== 1'b1 || sonuc !== 32'd3) begin errors++; $display("FAIL bp_next got ov=%b sonuc=%h want 1/00000003", out_valid, sonuc); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_illegal;
        drive(7'b0101010, 4'b0000, 32'd1234, 32'd5678, 32'd99);
        @(posedge clk); #1;
        $display("illegal opcode hata=%b we=%b sonuc=%h", hata, we, sonuc);
        checks++; if (out_valid !== 1'b1 || hata !== 1'b1) begin errors++; $display("FAIL ill_op got ov=%b hata=%b want 1/1", out_valid, hata); end
        checks++; if (we !== 1'b0 || sonuc !== 32'h0 || pc_update !== 1'b0) begin errors++; $display("FAIL ill_op_out got we=%b sonuc=%h pc=%b want 0/0/0", we, sonuc, pc_update); end
        drive(7'b0000001, 4'b0010, 32'd7, 32'd8, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("illegal func hata=%b we=%b sonuc=%h", hata, we, sonuc);
        checks++; if (hata !== 1'b1 || we !== 1'b0 || sonuc !== 32'h0) begin errors++; $display("FAIL ill_func got hata=%b we=%b sonuc=%h want 1/0/0", hata, we, sonuc); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int ov_seen;
        drive(7'b0011111, 4'b0000, 32'd7, 32'd9, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ov_seen = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ov_seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ov_seen++;
        end
        $display("reset mid-op out_valid cycles=%0d", ov_seen);
        checks++; if (ov_seen !== 0) begin errors++; $display("FAIL rmid_out_valid got %0d cycles want 0", ov_seen); end
        drive(7'b0000001, 4'b0110, 32'hF0, 32'h0F, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("after reset OR sonuc=%h", sonuc);
        checks++; if (out_valid !== 1'b1 || sonuc !== 32'hFF) begin errors++; $display("FAIL rmid_resume got ov=%b sonuc=%h want 1/000000ff", out_valid, sonuc); end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_branch();
        test_muldiv();
        test_div_zero();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
